benes_route_scheduler: RTL

- Configuration store and per-stage switch-setting sequencer for the Benes network_module datapath.
- Holds CFG_DEPTH programmed permutations, each with STAGE_NUM switch words.
- Accepts issue requests, one per cycle, each naming a permutation slot.
- Drives each stage's switch_set in lockstep with the data wavefront, so different permutations stream back-to-back with no bubbles.
- Returns a tagged out_valid when the permuted vector appears on the network output.

---
 rtl/benes_route_scheduler_pkg.sv | 22 ++
 rtl/benes_route_scheduler_cfg_table.sv | 49 ++++
 rtl/benes_route_scheduler.sv | 102 ++++++++++
 3 files changed

// File: rtl/benes_route_scheduler_pkg.sv
// Shared constants and token bundle for the Benes route scheduler.
// Stage words are indexed [slot][stage]; one bit per 2x2 switch.
package benes_route_scheduler_pkg;

    localparam int SIZE       = 32;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_LAT  = 2;
    localparam int CFG_DEPTH  = 8;
    localparam int TAG_W      = 8;

    localparam int LAT      = STAGE_LAT * (STAGE_NUM - 1) + 1;
    localparam int CFG_ID_W = $clog2(CFG_DEPTH);
    localparam int STAGE_W  = $clog2(STAGE_NUM);

    typedef struct packed {
        logic                valid;
        logic [CFG_ID_W-1:0] cfg_id;
        logic [TAG_W-1:0]    tag;
    } benes_token_t;

endpackage

// File: rtl/benes_route_scheduler_cfg_table.sv
// Permutation store: one write port, one read port per network stage.
// Owns the per-slot programmed flags.
module benes_cfg_table
    import benes_route_scheduler_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [CFG_ID_W-1:0]                  wr_slot,
    input  logic [STAGE_W-1:0]                   wr_stage,
    input  logic [SWITCH_NUM-1:0]                wr_data,
    input  logic                                 wr_last,
    input  logic [STAGE_NUM-1:0][CFG_ID_W-1:0]   rd_slot,
    output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] rd_data,
    output logic [CFG_DEPTH-1:0]                 slot_valid
);

    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_NUM - 1);

    logic [SWITCH_NUM-1:0] tbl [CFG_DEPTH][STAGE_NUM];
    logic                  wr_hit;

    // out-of-range stage indices are swallowed without side effects
    assign wr_hit = wr_en && (wr_stage <= STAGE_LAST);

    // table storage, no reset needed
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            tbl[wr_slot][wr_stage] <= wr_data;
        end
    end

    // slot is issuable only after its committing write
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
        end else if (wr_hit) begin
            slot_valid[wr_slot] <= wr_last;
        end
    end

    // each stage reads the word for the slot it currently holds
    always_comb begin
        for (int s = 0; s < STAGE_NUM; s++) begin
            rd_data[s] = tbl[rd_slot[s]][s];
        end
    end

endmodule

// File: rtl/benes_route_scheduler.sv
// Token pipeline that steers per-stage Benes switch settings
// in lockstep with the data wavefront.
module benes_route_scheduler
    import benes_route_scheduler_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_wr_en,
    input  logic [CFG_ID_W-1:0]                  cfg_wr_slot,
    input  logic [STAGE_W-1:0]                   cfg_wr_stage,
    input  logic [SWITCH_NUM-1:0]                cfg_wr_data,
    input  logic                                 cfg_wr_last,
    output logic                                 cfg_wr_ready,
    output logic [CFG_DEPTH-1:0]                 slot_valid,
    input  logic                                 in_valid,
    input  logic [CFG_ID_W-1:0]                  in_cfg_id,
    input  logic [TAG_W-1:0]                     in_tag,
    output logic                                 in_ready,
    output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] switch_set,
    output logic                                 out_valid,
    output logic [TAG_W-1:0]                     out_tag,
    output logic                                 busy
);

    benes_token_t pipe [1:LAT];
    benes_token_t stage_tok [STAGE_NUM];

    logic [STAGE_NUM-1:0][CFG_ID_W-1:0]   rd_slot;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] rd_data;
    logic [CFG_DEPTH-1:0]                 inflight;
    logic                                 issue;
    logic                                 wr_acc;

    // slots referenced by any token still in the pipeline
    always_comb begin
        inflight = '0;
        busy     = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (pipe[k].valid) begin
                inflight[pipe[k].cfg_id] = 1'b1;
                busy                     = 1'b1;
            end
        end
    end

    assign cfg_wr_ready = !inflight[cfg_wr_slot];
    assign wr_acc       = cfg_wr_en && cfg_wr_ready;

    // a pending write to the same slot beats the issue
    assign in_ready = slot_valid[in_cfg_id]
                   && !(cfg_wr_en && (cfg_wr_slot == in_cfg_id));
    assign issue    = in_valid && in_ready;

    // stage 0 is fed by the issuing token; later stages tap the pipe
    always_comb begin
        stage_tok[0].valid  = issue;
        stage_tok[0].cfg_id = in_cfg_id;
        stage_tok[0].tag    = in_tag;
        for (int s = 1; s < STAGE_NUM; s++) begin
            stage_tok[s] = pipe[s * STAGE_LAT];
        end
    end

    // idle stages fall back to bar setting
    always_comb begin
        for (int s = 0; s < STAGE_NUM; s++) begin
            rd_slot[s]    = stage_tok[s].cfg_id;
            switch_set[s] = stage_tok[s].valid ? rd_data[s] : '0;
        end
    end

    // token shift pipeline; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[1] <= stage_tok[0];
            for (int k = 2; k <= LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign out_valid = pipe[LAT].valid;
    assign out_tag   = pipe[LAT].valid ? pipe[LAT].tag : '0;

    benes_cfg_table u_cfg_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_acc),
        .wr_slot    (cfg_wr_slot),
        .wr_stage   (cfg_wr_stage),
        .wr_data    (cfg_wr_data),
        .wr_last    (cfg_wr_last),
        .rd_slot    (rd_slot),
        .rd_data    (rd_data),
        .slot_valid (slot_valid)
    );

endmodule
